// File: rtl/scarv_cop_palu_shift_iter_if.sv
// Request/response bundle for the iterative packed shifter.
// master = PALU control side, slave = the shifter itself.
interface scarv_cop_palu_shift_iter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [5:0]  req_shamt;
    logic [2:0]  req_pw;
    logic        req_sl;
    logic        req_r;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_c;
    logic        busy;

    modport master (
        output req_valid, req_a, req_shamt, req_pw, req_sl, req_r, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, busy
    );

    modport slave (
        input  req_valid, req_a, req_shamt, req_pw, req_sl, req_r, rsp_ready,
        output req_ready, rsp_valid, rsp_c, busy
    );
endinterface

// File: rtl/scarv_cop_palu_shift_iter.sv
// Iterative packed shifter/rotator: moves every lane one bit per cycle until
// the captured step count is exhausted, then holds the result until taken.
module scarv_cop_palu_shift_iter (
    input logic                         g_clk,
    input logic                         g_rst,
    scarv_cop_palu_shift_iter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  pw_q, pw_d;
    logic        sl_q, sl_d;
    logic        r_q, r_d;

    logic [5:0]  req_w;
    logic [5:0]  cur_w;
    logic [31:0] lsb_mask;
    logic [31:0] msb_mask;
    logic [31:0] step;

    // Lane width for a pack-width code; 0 marks an unsupported code.
    function automatic logic [5:0] lane_width(input logic [2:0] pw);
        case (pw)
            3'b001:  lane_width = 6'd32;
            3'b010:  lane_width = 6'd16;
            3'b011:  lane_width = 6'd8;
            3'b100:  lane_width = 6'd4;
            3'b101:  lane_width = 6'd2;
            default: lane_width = 6'd0;
        endcase
    endfunction

    // One bit set at the LSB of every lane.
    function automatic logic [31:0] lane_lsbs(input logic [2:0] pw);
        case (pw)
            3'b001:  lane_lsbs = 32'h0000_0001;
            3'b010:  lane_lsbs = 32'h0001_0001;
            3'b011:  lane_lsbs = 32'h0101_0101;
            3'b100:  lane_lsbs = 32'h1111_1111;
            3'b101:  lane_lsbs = 32'h5555_5555;
            default: lane_lsbs = 32'h0000_0000;
        endcase
    endfunction

    // Single-bit per-lane shift/rotate of the working register.
    always_comb begin
        req_w    = lane_width(bus.req_pw);
        cur_w    = lane_width(pw_q);
        lsb_mask = lane_lsbs(pw_q);
        msb_mask = lsb_mask << (cur_w - 6'd1);
        if (sl_q) begin
            step = (a_q << 1) & ~lsb_mask;
        end else if (r_q) begin
            // lane LSB wraps round to the lane MSB
            step = ((a_q >> 1) & ~msb_mask) | ((a_q & lsb_mask) << (cur_w - 6'd1));
        end else begin
            step = (a_q >> 1) & ~msb_mask;
        end
    end

    // Next-state logic: capture on accept, count down while shifting.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        pw_d    = pw_q;
        sl_d    = sl_q;
        r_d     = r_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    pw_d = bus.req_pw;
                    sl_d = bus.req_sl;
                    r_d  = bus.req_r;
                    if (req_w == 6'd0) begin
                        a_d   = 32'h0;
                        cnt_d = 6'd0;
                    end else begin
                        a_d = bus.req_a;
                        if (!bus.req_sl && bus.req_r) begin
                            cnt_d = bus.req_shamt & (req_w - 6'd1);
                        end else begin
                            cnt_d = (bus.req_shamt > req_w) ? req_w : bus.req_shamt;
                        end
                    end
                    state_d = (cnt_d == 6'd0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (cnt_q == 6'd0) begin
                    state_d = StDone;
                end else begin
                    a_d   = step;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state_q <= StIdle;
            a_q     <= 32'h0;
            cnt_q   <= 6'd0;
            pw_q    <= 3'b000;
            sl_q    <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            pw_q    <= pw_d;
            sl_q    <= sl_d;
            r_q     <= r_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_c     = a_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/scarv_cop_palu_shift_iter.md
# scarv_cop_palu_shift_iter

Iterative, area-reduced packed shifter/rotator for the SCARV coprocessor PALU. It is the sequenced counterpart to the single-cycle packed shifter. The PALU control issues one shift request over a valid/ready handshake. This block moves every packed lane by one bit position per cycle until the requested amount is done, then returns the result over a valid/ready response channel. It sits between the PALU instruction issue stage and the coprocessor writeback mux, and is selected when the low-area build option is enabled.

## Interface
- No parameters; datapath fixed at 32 bits.
- g_clk  in  1  clock; all state on rising edge
- g_rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  32  packed operand
- req_shamt  in  6  shift/rotate amount
- req_pw  in  3  pack width: 3'b001 = 1×32, 3'b010 = 2×16, 3'b011 = 4×8, 3'b100 = 8×4, 3'b101 = 16×2
- req_sl  in  1  1 = shift left, 0 = right
- req_r  in  1  1 = rotate right (ignored when req_sl = 1), 0 = logical shift
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_c  out  32  result
- busy  out  1  state ≠ IDLE

## Operation
- Lane width W = 32/P, where P is the lane count selected by req_pw.
- Lanes are independent. No bit crosses a lane boundary.
- Required per-lane semantics:
  - Left shift: lane << shamt, truncated to W bits.
  - Right logical shift: lane >> shamt, zero fill.
  - Rotate right: rotate by (shamt mod W).
  - Shift by shamt ≥ W yields 0.
- Unsupported req_pw (000, 110, 111): the request is accepted and the result is 0x00000000 after 1 SHIFT-free cycle (count = 0).
- Captured at acceptance (req_valid & req_ready):
  - operand into the working register
  - pw, sl, r into control registers
  - step count N:
    - shift: min(shamt, W)
    - rotate: shamt mod W
    - unsupported pw: 0
- States:
  - IDLE: req_ready = 1. On accept, go to SHIFT if N > 0, else DONE.
  - SHIFT: each cycle, every lane shifts or rotates by one bit and N decrements. When N = 1 is consumed, go to DONE.
  - DONE: rsp_valid = 1 and rsp_c = working register. On rsp_ready, go to IDLE.
- One request in flight at a time. req_ready is 0 in SHIFT and in DONE. No request can be accepted in the cycle the response is taken.
- Left shift by one inserts 0 at each lane LSB. Right shift inserts 0 at each lane MSB. Rotate inserts the lane LSB at the lane MSB.

## Timing
- Reset values: state IDLE, req_ready = 1, rsp_valid = 0, rsp_c = 0, busy = 0, working register 0, count 0.
- Reset asserted mid-operation aborts immediately. There is no response for the aborted request, and outputs return to reset values asynchronously.
- Acceptance edge = cycle 0. rsp_valid rises after the edge at cycle N+1.
  - N = 0: rsp_valid in the cycle after acceptance.
  - N = 32 (1×32 shift with shamt ≥ 32): 33 cycles.
- rsp_c and rsp_valid are stable while rsp_valid & !rsp_ready. They may be held indefinitely.
- rsp_c is registered. No input reaches any output combinationally except through state.
- req_* inputs are sampled only at acceptance. Changes during SHIFT/DONE have no effect.
- The 6-bit counter never underflows. When count = 0 in SHIFT, the state is left without shifting.

## Test plan
- pw = 011, sl = 1, a = 0x8001FF10, shamt = 1 -> rsp_c = 0x0002FE20. rsp_valid 2 cycles after accept.
- pw = 010, sl = 0, r = 1, a = 0x00018000, shamt = 1 -> rsp_c = 0x80004000. Also with shamt = 17 (mod 16 = 1) -> same value, latency 2.
- pw = 001, sl = 0, r = 0, a = 0xFFFFFFFF, shamt = 40 -> rsp_c = 0x00000000. rsp_valid exactly 33 cycles after accept.
- pw = 101, r = 1, sl = 0, a = 0x00000001, shamt = 3 -> rsp_c = 0x00000002. With shamt = 0 -> rsp_c = 0x00000001 after 1 cycle.
- Backpressure: hold rsp_ready = 0 for 5 cycles in DONE -> rsp_c stable, req_ready = 0, busy = 1. A new req_valid with different data during this time does not change the result. Raising rsp_ready returns to IDLE next cycle.
- Assert g_rst for 1 cycle mid-SHIFT (pw = 001, shamt = 20, after 5 steps) -> all outputs reset asynchronously, no response. The next request completes correctly.
